// File: rtl/reg_access_pkg.sv
// Shared types and constants for the register-access initiator.
// Holds the FSM state type, default widths and the read/write opcode encoding.
package reg_access_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Register accesses must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/reg_access_initiator_txn_timer.sv
// Transaction watchdog: counts ISSUE/WAIT_RD cycles and flags the cycle
// in which the count reaches TIMEOUT_CYCLES.
module txn_timer
    import reg_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, then saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/reg_access_initiator.sv
// Host-command to register-file bridge, one transaction in flight at a time.
// Optional watchdog abort enabled by defining REG_ACCESS_TIMEOUT_EN.
module reg_access_initiator
    import reg_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rd_data,
    output logic                  rsp_err,
    output logic                  mst_o_valid,
    output logic [ADDR_WIDTH-1:0] mst_o_addr,
    output logic [DATA_WIDTH-1:0] mst_o_wr_data,
    output logic                  mst_o_rd0_wr1,
    input  logic                  mst_i_ready,
    input  logic [DATA_WIDTH-1:0] mst_i_read_data,
    input  logic                  mst_i_rd_valid
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  mst_valid_q, mst_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  op_q, op_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  timeout_s;

`ifdef REG_ACCESS_TIMEOUT_EN
    logic timer_clear_s;
    logic timer_en_s;

    assign timer_clear_s = (state_q == IDLE) && (state_d == ISSUE);
    assign timer_en_s    = (state_q == ISSUE) || (state_q == WAIT_RD);

    txn_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_txn_timer (
        .clk_i     (i_clk),
        .rstn_i    (i_rstn),
        .clear_i   (timer_clear_s),
        .en_i      (timer_en_s),
        .expired_o (timeout_s)
    );
`else
    logic timeout_unused_s;

    assign timeout_unused_s = (TIMEOUT_CYCLES > 0);
    assign timeout_s        = 1'b0;
`endif

    // Next-state and next-output decode; a handshake or rd_valid beats a timeout.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wr_data;
                    op_d       = cmd_rd0_wr1;
                    rsp_data_d = '0;
                    rsp_err_d  = is_misaligned(cmd_addr[1:0]);
                    state_d    = is_misaligned(cmd_addr[1:0]) ? RESP : ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mst_i_ready) begin
                    case (op_q)
                        OP_WRITE: state_d = RESP;
                        OP_READ:  state_d = WAIT_RD;
                        default:  state_d = RESP;
                    endcase
                end else if (timeout_s) begin
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_RD: begin
                if (mst_i_rd_valid) begin
                    rsp_data_d = mst_i_read_data;
                    state_d    = RESP;
                end else if (timeout_s) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    state_d = WAIT_RD;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
        mst_valid_d = (state_d == ISSUE);
        rsp_valid_d = (state_d == RESP);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            mst_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            mst_valid_q <= mst_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign mst_o_valid   = mst_valid_q;
    assign mst_o_addr    = addr_q;
    assign mst_o_wr_data = wdata_q;
    assign mst_o_rd0_wr1 = op_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rd_data   = rsp_data_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_reg_access_initiator.sv
// Self-checking bench for reg_access_initiator: directed vector table,
// randomized transactions against a latency/result model, reset corner cases.
module tb_reg_access_initiator;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        cmd_valid, cmd_ready, cmd_rd0_wr1;
    logic [31:0] cmd_addr, cmd_wr_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rd_data;
    logic        mst_o_valid, mst_o_rd0_wr1;
    logic [31:0] mst_o_addr, mst_o_wr_data;
    logic        mst_i_ready, mst_i_rd_valid;
    logic [31:0] mst_i_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    reg_access_initiator dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_rd0_wr1     (cmd_rd0_wr1),
        .cmd_addr        (cmd_addr),
        .cmd_wr_data     (cmd_wr_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rd_data     (rsp_rd_data),
        .rsp_err         (rsp_err),
        .mst_o_valid     (mst_o_valid),
        .mst_o_addr      (mst_o_addr),
        .mst_o_wr_data   (mst_o_wr_data),
        .mst_o_rd0_wr1   (mst_o_rd0_wr1),
        .mst_i_ready     (mst_i_ready),
        .mst_i_read_data (mst_i_read_data),
        .mst_i_rd_valid  (mst_i_rd_valid)
    );

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rd_dly;
        int          rsp_dly;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_issue;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Runs one command while playing the register file and the host response side.
    task automatic do_txn(input vec_t v, input string tag);
        int   cyc, lat, issue_cnt, hs_cnt, hs_cyc, field_bad, rsp_bad, rsp_cnt, wait_cnt;
        logic delivered, done, got_rsp;
        logic [31:0] first_data;
        logic first_err;
        lat = -1; issue_cnt = 0; hs_cnt = 0; hs_cyc = -1; field_bad = 0; rsp_bad = 0;
        rsp_cnt = 0; delivered = 1'b0; done = 1'b0; got_rsp = 1'b0;
        first_data = 32'd0; first_err = 1'b0; wait_cnt = 0;
        while (!cmd_ready && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        check({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_rd0_wr1 = v.op; cmd_addr = v.addr; cmd_wr_data = v.wdata;
        step();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wr_data = $urandom; cmd_rd0_wr1 = 1'($urandom);
        cyc = 1;
        while (!done && cyc < 300) begin
            mst_i_ready = 1'b0;
            if (mst_o_valid) begin
                issue_cnt++;
                if (mst_o_addr !== v.addr || mst_o_wr_data !== v.wdata || mst_o_rd0_wr1 !== v.op)
                    field_bad++;
                if (issue_cnt - 1 == v.rdy_dly) begin
                    mst_i_ready = 1'b1;
                    hs_cnt++;
                    hs_cyc = cyc;
                end
            end
            if (v.op == 1'b0 && hs_cyc >= 0 && !delivered && cyc > hs_cyc) begin
                mst_i_rd_valid  = (cyc == hs_cyc + 1 + v.rd_dly);
                mst_i_read_data = mst_i_rd_valid ? v.rdata : 32'd0;
                if (mst_i_rd_valid) delivered = 1'b1;
            end else begin
                mst_i_rd_valid  = 1'($urandom_range(0, 1));
                mst_i_read_data = $urandom;
            end
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (!got_rsp) begin
                    got_rsp = 1'b1; lat = cyc; first_data = rsp_rd_data; first_err = rsp_err;
                end else if (rsp_rd_data !== first_data || rsp_err !== first_err) begin
                    rsp_bad++;
                end
                rsp_cnt++;
                if (rsp_cnt - 1 == v.rsp_dly) begin
                    rsp_ready = 1'b1;
                    done = 1'b1;
                end
            end
            step();
            cyc++;
        end
        rsp_ready = 1'b0; mst_i_ready = 1'b0; mst_i_rd_valid = 1'b0;
        check({tag, " completed"}, {31'd0, done}, 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " rsp_err"}, {31'd0, first_err}, {31'd0, v.exp_err});
        check({tag, " rsp_rd_data"}, first_data, v.exp_data);
        check({tag, " issue cycles"}, 32'(issue_cnt), 32'(v.exp_issue));
        check({tag, " handshakes"}, 32'(hs_cnt), (v.exp_issue > 0) ? 32'd1 : 32'd0);
        check({tag, " mst fields stable"}, 32'(field_bad), 32'd0);
        check({tag, " rsp stable"}, 32'(rsp_bad), 32'd0);
        check({tag, " rsp_valid drops"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    // Reference model: fills expected fields from the protocol rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.addr[1:0] != 2'b00) begin
            r.exp_err = 1'b1; r.exp_data = 32'd0; r.exp_lat = 1; r.exp_issue = 0;
        end else if (v.op) begin
            r.exp_err = 1'b0; r.exp_data = 32'd0; r.exp_lat = 2 + v.rdy_dly; r.exp_issue = v.rdy_dly + 1;
        end else begin
            r.exp_err = 1'b0; r.exp_data = v.rdata; r.exp_lat = 3 + v.rdy_dly + v.rd_dly;
            r.exp_issue = v.rdy_dly + 1;
        end
        return r;
    endfunction

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int   pulses;
        vecs[0] = '{1'b1, 32'h4,  32'hDEADBEEF, 32'h0,        0, 0, 0, 1'b0, 32'h0,        2, 1};
        vecs[1] = '{1'b0, 32'h8,  32'h0,        32'h12345678, 0, 0, 0, 1'b0, 32'h12345678, 3, 1};
        vecs[2] = '{1'b1, 32'hC,  32'hA5A5A5A5, 32'h0,        5, 0, 0, 1'b0, 32'h0,        7, 6};
        vecs[3] = '{1'b1, 32'h6,  32'h55AA55AA, 32'h0,        0, 0, 0, 1'b1, 32'h0,        1, 0};
        vecs[4] = '{1'b0, 32'h1,  32'h0,        32'hCAFEF00D, 0, 0, 0, 1'b1, 32'h0,        1, 0};
        vecs[5] = '{1'b0, 32'h10, 32'h0,        32'h0BADF00D, 2, 3, 4, 1'b0, 32'h0BADF00D, 8, 3};
        vecs[6] = '{1'b1, 32'h14, 32'h11223344, 32'h0,        1, 0, 2, 1'b0, 32'h0,        3, 2};
        vecs[7] = '{1'b0, 32'h3,  32'h0,        32'h77777777, 0, 0, 4, 1'b1, 32'h0,        1, 0};

        i_rstn = 1'b0; cmd_valid = 1'b1; cmd_rd0_wr1 = 1'b1; cmd_addr = 32'h4;
        cmd_wr_data = 32'hFFFFFFFF; rsp_ready = 1'b1; mst_i_ready = 1'b1;
        mst_i_rd_valid = 1'b1; mst_i_read_data = 32'hFFFFFFFF;
        repeat (3) step();
        check("reset ctrl bits", {27'd0, cmd_ready, mst_o_valid, mst_o_rd0_wr1, rsp_valid, rsp_err}, 32'd0);
        check("reset mst_o_addr", mst_o_addr, 32'd0);
        check("reset mst_o_wr_data", mst_o_wr_data, 32'd0);
        check("reset rsp_rd_data", rsp_rd_data, 32'd0);
        cmd_valid = 1'b0; rsp_ready = 1'b0; mst_i_ready = 1'b0; mst_i_rd_valid = 1'b0;
        i_rstn = 1'b1;
        step();
        check("cmd_ready after reset", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv = '{1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1'b0, 32'h0, 0, 0};
            rv.op = 1'($urandom);
            rv.addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rv.addr[1:0] = 2'($urandom_range(1, 3));
            rv.wdata = $urandom; rv.rdata = $urandom;
            rv.rdy_dly = $urandom_range(0, 4); rv.rd_dly = $urandom_range(0, 4);
            rv.rsp_dly = $urandom_range(0, 3);
            do_txn(model(rv), $sformatf("rand%0d", i));
        end

`ifdef REG_ACCESS_TIMEOUT_EN
        rv = '{1'b0, 32'h18, 32'h0, 32'h99999999, 0, 1000, 4, 1'b1, 32'h0, 17, 1};
        do_txn(rv, "timeout read");
`endif

        // Reset while waiting for read data: aborted silently.
        cmd_valid = 1'b1; cmd_rd0_wr1 = 1'b0; cmd_addr = 32'h20;
        step();
        cmd_valid = 1'b0; mst_i_ready = 1'b1;
        step();
        mst_i_ready = 1'b0;
        check("wait_rd mst_o_valid", {31'd0, mst_o_valid}, 32'd0);
        i_rstn = 1'b0;
        step();
        i_rstn = 1'b1;
        check("mid-reset ctrl bits", {27'd0, cmd_ready, mst_o_valid, mst_o_rd0_wr1, rsp_valid, rsp_err}, 32'd0);
        check("mid-reset mst_o_addr", mst_o_addr, 32'd0);
        check("mid-reset rsp_rd_data", rsp_rd_data, 32'd0);
        pulses = 0;
        mst_i_rd_valid = 1'b1; mst_i_read_data = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid) pulses++;
        end
        mst_i_rd_valid = 1'b0;
        check("no rsp after reset", 32'(pulses), 32'd0);
        check("idle after reset", {31'd0, cmd_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
